// File: rtl/ceyloniac_loader_pkg.sv
// Shared constants and types for the regfile command loader.
package ceyloniac_loader_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [7:0] OP_ENABLE = 8'h45;
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CTRL,
        ST_DATA,
        ST_WRITE,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_RESP
    } state_t;

    function automatic logic addr_ok(input logic [7:0] b);
        return b[7:ADDR_W] == '0;
    endfunction

endpackage

// File: rtl/ceyloniac_loader_timeout.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while a
// command is waiting for its next byte, flags expiry at zero.
module ceyloniac_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded one short so expiry is seen on the last permitted idle cycle.
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= LOAD;
        end else if (run_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ceyloniac_regfile_loader.sv
// Byte-stream command loader that drives the external port set of
// ceyloniac_regfile_controller: enable takeover, register write and read-back.
//
// state      | meaning
// IDLE       | waiting for opcode byte; opcode decoded on acceptance
// ADDR       | waiting for address byte (W or R)
// CTRL       | waiting for enable argument byte (E)
// DATA       | collecting 4 write data bytes, LSB first
// WRITE      | one-cycle write strobe
// RD_WAIT    | read address applied, capture read_data1 at end of cycle
// RD_SEND    | sending 4 read bytes, LSB first
// RESP       | sending a single ACK/NAK byte
module ceyloniac_regfile_loader
    import ceyloniac_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              reg_external_control_enable,
    output logic [ADDR_W-1:0] external_write_addr,
    output logic [DATA_W-1:0] external_write_data,
    output logic              external_write_enable,
    output logic [ADDR_W-1:0] external_read_addr1,
    input  logic [DATA_W-1:0] read_data1,
    output logic              cmd_error
);

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        resp_q, resp_d;
    logic              err_q, err_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              waiting, rx_fire, tx_fire, expired;

    assign waiting  = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CTRL);
    assign rx_ready = !rst && (waiting || state_q == ST_IDLE);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_valid = (state_q == ST_RESP) || (state_q == ST_RD_SEND);
    assign tx_data  = (state_q == ST_RESP)    ? resp_q :
                      (state_q == ST_RD_SEND) ? word_q[7:0] : 8'h00;
    assign tx_fire  = tx_valid && tx_ready;

    ceyloniac_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (rx_fire),
        .run_i     (waiting),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            en_q    <= en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = 1'b0;
        en_d    = en_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        raddr_d = raddr_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (rx_data)
                        OP_ENABLE: state_d = ST_CTRL;
                        OP_WRITE: begin
                            is_wr_d = 1'b1;
                            state_d = ST_ADDR;
                        end
                        OP_READ: begin
                            is_wr_d = 1'b0;
                            state_d = ST_ADDR;
                        end
                        default: begin
                            err_d   = 1'b1;
                            resp_d  = RSP_NAK;
                            state_d = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    if (!addr_ok(rx_data)) begin
                        err_d   = 1'b1;
                        resp_d  = RSP_NAK;
                        state_d = ST_RESP;
                    end else if (is_wr_q) begin
                        addr_d  = rx_data[ADDR_W-1:0];
                        cnt_d   = 2'd0;
                        state_d = ST_DATA;
                    end else if (en_q) begin
                        raddr_d = rx_data[ADDR_W-1:0];
                        state_d = ST_RD_WAIT;
                    end else begin
                        resp_d  = RSP_NAK;
                        state_d = ST_RESP;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    resp_d  = RSP_NAK;
                    state_d = ST_RESP;
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    word_d = {rx_data, word_q[DATA_W-1:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Locked-out writes still swallow all bytes, then NAK.
                        if (en_q) begin
                            waddr_d = addr_q;
                            wdata_d = {rx_data, word_q[DATA_W-1:8]};
                            state_d = ST_WRITE;
                        end else begin
                            resp_d  = RSP_NAK;
                            state_d = ST_RESP;
                        end
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    resp_d  = RSP_NAK;
                    state_d = ST_RESP;
                end
            end
            ST_CTRL: begin
                if (rx_fire) begin
                    en_d    = rx_data[0];
                    resp_d  = RSP_ACK;
                    state_d = ST_RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    resp_d  = RSP_NAK;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                resp_d  = RSP_ACK;
                state_d = ST_RESP;
            end
            ST_RD_WAIT: begin
                word_d  = read_data1;
                cnt_d   = 2'd0;
                state_d = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (tx_fire) begin
                    word_d = {8'h00, word_q[DATA_W-1:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign reg_external_control_enable = en_q;
    assign external_write_addr         = waddr_q;
    assign external_write_data         = wdata_q;
    assign external_write_enable       = (state_q == ST_WRITE);
    assign external_read_addr1         = raddr_q;
    assign cmd_error                   = err_q;

endmodule

// File: tb/tb_ceyloniac_regfile_loader.sv
// Bench for ceyloniac_regfile_loader: command-level model plus directed vectors.
module tb_ceyloniac_regfile_loader;

    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        reg_external_control_enable;
    logic [4:0]  external_write_addr;
    logic [31:0] external_write_data;
    logic        external_write_enable;
    logic [4:0]  external_read_addr1;
    logic [31:0] read_data1;
    logic        cmd_error;

    ceyloniac_regfile_loader #(.TIMEOUT_CYCLES(T)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .rx_data                     (rx_data),
        .rx_valid                    (rx_valid),
        .rx_ready                    (rx_ready),
        .tx_data                     (tx_data),
        .tx_valid                    (tx_valid),
        .tx_ready                    (tx_ready),
        .reg_external_control_enable (reg_external_control_enable),
        .external_write_addr         (external_write_addr),
        .external_write_data         (external_write_data),
        .external_write_enable       (external_write_enable),
        .external_read_addr1         (external_read_addr1),
        .read_data1                  (read_data1),
        .cmd_error                   (cmd_error)
    );

    // Register file stand-in on the controller side.
    logic [31:0] mem [32];
    assign read_data1 = mem[external_read_addr1];

    int total = 0;
    int bad   = 0;
    int tx_mode = 0;

    // Command-level model
    logic [7:0]  cmd [$];
    logic [7:0]  exp_tx [$];
    logic [36:0] exp_wr [$];
    logic [7:0]  got_tx [$];
    logic [31:0] exp_mem [32];
    int          exp_err;
    logic        m_en;
    int          idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cmd.delete();
        exp_tx.delete();
        exp_wr.delete();
        exp_err = 0;
        m_en = 1'b0;
        idle = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0]  op;
        logic [7:0]  ab;
        logic [31:0] d;
        idle = 0;
        if (cmd.size() == 0) begin
            if (b == 8'h45 || b == 8'h57 || b == 8'h52) begin
                cmd.push_back(b);
            end else begin
                exp_err++;
                exp_tx.push_back(8'h15);
            end
        end else begin
            cmd.push_back(b);
            op = cmd[0];
            if (cmd.size() == 2 && op != 8'h45 && b[7:5] != 3'b000) begin
                exp_err++;
                exp_tx.push_back(8'h15);
                cmd.delete();
            end else if (op == 8'h45) begin
                m_en = b[0];
                exp_tx.push_back(8'h06);
                cmd.delete();
            end else if (op == 8'h52) begin
                if (m_en) begin
                    d = exp_mem[b[4:0]];
                    for (int i = 0; i < 4; i++) exp_tx.push_back(8'(d >> (8 * i)));
                end else begin
                    exp_tx.push_back(8'h15);
                end
                cmd.delete();
            end else if (cmd.size() == 6) begin
                ab = cmd[1];
                d  = {cmd[5], cmd[4], cmd[3], cmd[2]};
                if (m_en) begin
                    exp_wr.push_back({ab[4:0], d});
                    exp_mem[ab[4:0]] = d;
                    exp_tx.push_back(8'h06);
                end else begin
                    exp_tx.push_back(8'h15);
                end
                cmd.delete();
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 1) == 1);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (external_write_enable) mem[external_write_addr] = external_write_data;
        end
    end

    // Compare process: every cycle against the model.
    initial begin
        logic        pv, pr, prst;
        logic [7:0]  pd, e;
        logic [36:0] w;
        pv = 1'b0; pr = 1'b0; prst = 1'b1; pd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
            end else begin
                if (tx_valid && tx_ready) begin
                    got_tx.push_back(tx_data);
                    if (exp_tx.size() == 0) begin
                        chk("unexpected tx byte", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx byte", 32'(tx_data), 32'(e));
                    end
                end
                if (external_write_enable) begin
                    chk("write and error overlap", 32'(cmd_error), 0);
                    if (exp_wr.size() == 0) begin
                        chk("unexpected write strobe", 1, 0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("write addr", 32'(external_write_addr), 32'(w[36:32]));
                        chk("write data", external_write_data, w[31:0]);
                    end
                end
                if (cmd_error) begin
                    if (exp_err == 0) chk("unexpected cmd_error", 1, 0);
                    else exp_err--;
                end
                chk("enable", 32'(reg_external_control_enable), 32'(m_en));
                if (tx_valid) chk("rx_ready low while sending", 32'(rx_ready), 0);
                if (pv && !pr && !prst) begin
                    chk("tx hold valid", 32'(tx_valid), 1);
                    chk("tx hold data", 32'(tx_data), 32'(pd));
                end
                if (rx_valid && rx_ready) begin
                    model_byte(rx_data);
                end else if (cmd.size() != 0) begin
                    idle++;
                    if (idle == T) begin
                        exp_err++;
                        exp_tx.push_back(8'h15);
                        cmd.delete();
                        idle = 0;
                    end
                end
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) chk("rx accept bound", 0, 1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_err != 0 || tx_valid) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("drain pending", 32'(exp_tx.size() + exp_wr.size() + exp_err), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " rx_ready"}, 32'(rx_ready), 0);
        chk({tag, " tx_valid"}, 32'(tx_valid), 0);
        chk({tag, " tx_data"}, 32'(tx_data), 0);
        chk({tag, " enable"}, 32'(reg_external_control_enable), 0);
        chk({tag, " waddr"}, 32'(external_write_addr), 0);
        chk({tag, " wdata"}, external_write_data, 0);
        chk({tag, " we"}, 32'(external_write_enable), 0);
        chk({tag, " raddr"}, 32'(external_read_addr1), 0);
        chk({tag, " cmd_error"}, 32'(cmd_error), 0);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'h57);
        send_byte(a);
        for (int i = 0; i < 4; i++) send_byte(8'(d >> (8 * i)));
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        model_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_mode = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready after reset", 32'(rx_ready), 1);
        @(posedge clk);
        #1;

        // Locked out: write then read while disabled.
        send_write(8'h01, 32'hDDCC_BBAA);
        @(negedge clk);
        chk("locked no strobe", 32'(external_write_enable), 0);
        chk("locked nak valid", 32'(tx_valid), 1);
        chk("locked nak byte", 32'(tx_data), 32'h15);
        wait_idle();
        got_tx.delete();
        send_cmd(8'h52, 8'h05);
        wait_idle();
        chk("locked read count", 32'(got_tx.size()), 1);
        if (got_tx.size() > 0) chk("locked read nak", 32'(got_tx[0]), 32'h15);

        // Enable, then write with latency pinned.
        send_cmd(8'h45, 8'h01);
        wait_idle();
        chk("enable set", 32'(reg_external_control_enable), 1);
        send_write(8'h03, 32'h1234_5678);
        @(negedge clk);
        chk("we cycle after d3", 32'(external_write_enable), 1);
        chk("we addr", 32'(external_write_addr), 3);
        chk("we data", external_write_data, 32'h1234_5678);
        chk("no ack during strobe", 32'(tx_valid), 0);
        @(negedge clk);
        chk("we one cycle", 32'(external_write_enable), 0);
        chk("write ack valid", 32'(tx_valid), 1);
        chk("write ack byte", 32'(tx_data), 32'h06);
        wait_idle();
        chk("addr holds", 32'(external_write_addr), 3);
        chk("data holds", external_write_data, 32'h1234_5678);

        // Readback with a long tx stall then random ready.
        got_tx.delete();
        tx_mode = 2;
        send_cmd(8'h52, 8'h03);
        @(negedge clk);
        chk("read addr applied", 32'(external_read_addr1), 3);
        chk("rd_wait no tx", 32'(tx_valid), 0);
        @(negedge clk);
        chk("first read byte valid", 32'(tx_valid), 1);
        chk("first read byte", 32'(tx_data), 32'h78);
        repeat (30) @(negedge clk);
        chk("stall holds valid", 32'(tx_valid), 1);
        chk("stall holds byte", 32'(tx_data), 32'h78);
        @(posedge clk);
        #1;
        tx_mode = 1;
        wait_idle();
        tx_mode = 0;
        chk("readback count", 32'(got_tx.size()), 4);
        if (got_tx.size() == 4) begin
            chk("readback b0", 32'(got_tx[0]), 32'h78);
            chk("readback b1", 32'(got_tx[1]), 32'h56);
            chk("readback b2", 32'(got_tx[2]), 32'h34);
            chk("readback b3", 32'(got_tx[3]), 32'h12);
        end

        // Bad address, then normal enable.
        send_cmd(8'h57, 8'h20);
        @(negedge clk);
        chk("bad addr error", 32'(cmd_error), 1);
        chk("bad addr nak", 32'(tx_data), 32'h15);
        wait_idle();
        got_tx.delete();
        send_cmd(8'h45, 8'h01);
        wait_idle();
        chk("enable after error", 32'(got_tx.size() == 1 ? got_tx[0] : 8'hEE), 32'h06);

        // Unknown opcode.
        send_byte(8'h33);
        @(negedge clk);
        chk("bad opcode error", 32'(cmd_error), 1);
        chk("bad opcode nak", 32'(tx_data), 32'h15);
        wait_idle();

        // Boundary address and read of an untouched register, random ready.
        tx_mode = 1;
        send_write(8'h1F, 32'hDEAD_BEEF);
        wait_idle();
        send_cmd(8'h52, 8'h1F);
        wait_idle();
        send_cmd(8'h52, 8'h00);
        wait_idle();
        tx_mode = 0;

        // Timeout after a partial write.
        send_byte(8'h57);
        send_byte(8'h02);
        send_byte(8'h11);
        pulses = 0;
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            if (cmd_error) pulses++;
        end
        chk("no early timeout", 32'(pulses), 0);
        @(negedge clk);
        chk("timeout error", 32'(cmd_error), 1);
        chk("timeout nak", 32'(tx_data), 32'h15);
        wait_idle();
        chk("timeout no write", mem[2], 0);

        // Reset in the middle of a write.
        send_byte(8'h57);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_zero("mid reset");
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready after mid reset", 32'(rx_ready), 1);
        repeat (10) @(negedge clk);
        chk("mid reset no write", mem[4], 0);
        @(posedge clk);
        #1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ceyloniac_regfile_loader.md
# ceyloniac_regfile_loader

Byte-stream command loader that sits directly upstream of `ceyloniac_regfile_controller` and drives its external port set. It lets a host, such as a UART bridge or debug port, take over the register file, write registers, and read them back before releasing control to the core. Inbound commands arrive as a valid/ready byte stream, and responses leave on a second valid/ready byte stream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum idle cycles between bytes of one command before it is aborted.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `rx_data`  in  8  inbound command byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts a byte this cycle
- `tx_data`  out  8  response byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  downstream accepts `tx_data`
- `reg_external_control_enable`  out  1  to controller; selects external ports
- `external_write_addr`  out  5  register write address
- `external_write_data`  out  32  register write data
- `external_write_enable`  out  1  one-cycle write strobe
- `external_read_addr1`  out  5  register read address
- `read_data1`  in  32  controller read port 1 data, combinational from `external_read_addr1`
- `cmd_error`  out  1  one-cycle pulse on any protocol error

## Operation
**Byte transfer**
- A byte is accepted when `rx_valid && rx_ready`.
- A byte is sent when `tx_valid && tx_ready`.
- `tx_valid`/`tx_data` are held stable until accepted.

**Commands**
- `E`, enable (0x45, then 1 byte):
  - bit0 of the second byte is latched into `reg_external_control_enable`.
  - Respond ACK 0x06.
- `W`, write (0x57, addr, d0, d1, d2, d3):
  - Data is little-endian: d0 is bits 7:0.
  - Assert `external_write_enable` for exactly 1 cycle with the addr and data, then send ACK.
  - Address and data outputs hold their last values afterwards.
- `R`, read (0x52, addr):
  - Drive `external_read_addr1`, wait 1 cycle (RD_WAIT), capture `read_data1`.
  - Send 4 bytes, LSB first.

**Rejections and errors**
- `W`/`R` received while `reg_external_control_enable` = 0:
  - All bytes are consumed.
  - No write occurs and no read data is returned.
  - Respond NAK 0x15.
- Error conditions, each causing a `cmd_error` pulse, a NAK, and a return to IDLE:
  - unknown opcode
  - addr byte with bits 7:5 nonzero
  - inter-byte timeout

**States**
- IDLE → OPCODE decode → ADDR (W/R) or CTRL (E).
- ADDR → DATA (W, 4 bytes, 2-bit counter) → WRITE → RESP.
- ADDR → RD_WAIT → RD_SEND (counter 0..3) → IDLE.
- CTRL → RESP → IDLE.
- Any error → RESP (NAK) → IDLE.
- `rx_ready` = 1 only in IDLE, ADDR, DATA, CTRL. It is 0 in WRITE, RD_WAIT, RD_SEND, RESP.

## Timing
- Reset values: state IDLE; every output 0; `rx_ready` becomes 1 on the first cycle after reset deasserts; the captured data word, counters and timeout counter are all 0.
- `rst` mid-command: the command is dropped, no write strobe is issued, and any pending tx byte is discarded. `reg_external_control_enable` returns to 0, which returns the register file to the core.
- `W` latency: `external_write_enable` is high in the cycle after d3 is accepted. ACK `tx_valid` rises on the following cycle.
- `R` latency: `external_read_addr1` is valid the cycle after addr is accepted. Data is captured at the end of RD_WAIT. The first `tx_valid` appears 2 cycles after addr acceptance.
- Timeout:
  - The counter runs in ADDR, DATA and CTRL.
  - It resets on every accepted byte.
  - Abort occurs when the count reaches `TIMEOUT_CYCLES` with no byte accepted.
- `tx_ready` held low indefinitely: the loader stalls in RESP or RD_SEND, never drops bytes, and does not time out.
- `cmd_error` and `external_write_enable` never assert in the same cycle.

## Structure
- Shared package `ceyloniac_loader_pkg`: opcode constants (0x45, 0x57, 0x52), ACK/NAK codes, state enum, register address width (5) and data width (32).
- One natural sub-module, `ceyloniac_loader_timeout`: a loadable down-counter with a clear-on-byte input and an `expired` output.
- Byte assembly and the FSM stay in the top module.

## Test plan
- **Enable then write:** send 45 01, then 57 03 78 56 34 12 → `reg_external_control_enable` = 1, ACK; one-cycle `external_write_enable` with addr 3 and data 0x12345678, then ACK 0x06.
- **Readback:** with the regfile model holding 0x12345678 at addr 3, send 52 03 → tx bytes 78 56 34 12 in order, with `tx_ready` toggled randomly and no bytes lost.
- **Locked out:** with enable = 0, send 57 01 AA BB CC DD → no write strobe; NAK 0x15.
- **Bad address:** send 57 20 → `cmd_error` pulse, NAK, return to IDLE; the next 45 01 is accepted normally.
- **Timeout:** `TIMEOUT_CYCLES` = 8; send 57 02 11, then idle 8 cycles → `cmd_error`, NAK, no write.
- **Reset mid-command:** send 57 04 11 22, then `rst` for 1 cycle → no write strobe; all outputs 0; `rx_ready` = 1 the next cycle.
